// File: rtl/add_pipe2.sv
// Two-stage pipelined operand-pair adder with valid/ready on both sides.
// Build option: define ADD_PIPE2_SAT_EN to saturate out_sum to all ones on carry-out.
module add_pipe2 #(
  parameter int unsigned DW    = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] out_cnt
);

  // Occupancy encoded as {s1_v, s2_v}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    TAIL  = 2'b01,
    HEAD  = 2'b10,
    FULL  = 2'b11
  } occ_t;

  occ_t          state;
  occ_t          state_nxt;
  logic          s1_v;
  logic          s2_v;
  logic          s1_adv;
  logic          s2_adv;
  logic          in_xfer;
  logic          out_xfer;
  logic [DW-1:0] s1_a;
  logic [DW-1:0] s1_b;
  logic [DW:0]   sum_w;
  logic [DW-1:0] sum_d;

  assign s1_v = state[1];
  assign s2_v = state[0];

  // Occupancy register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Advance rules and occupancy next state
  always_comb begin
    s2_adv    = 1'b0;
    s1_adv    = 1'b0;
    state_nxt = state;
    s2_adv    = !s2_v || out_ready;
    s1_adv    = !s1_v || s2_adv;
    case (state)
      EMPTY:   state_nxt = in_valid ? HEAD : EMPTY;
      HEAD:    state_nxt = in_valid ? FULL : TAIL;
      TAIL: begin
        if (out_ready) state_nxt = in_valid ? HEAD : EMPTY;
        else           state_nxt = in_valid ? FULL : TAIL;
      end
      FULL: begin
        if (out_ready) state_nxt = in_valid ? FULL : TAIL;
        else           state_nxt = FULL;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_v;
  assign in_xfer   = in_valid && s1_adv;
  assign out_xfer  = s2_v && out_ready;

  // Stage 1 operand capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_a <= '0;
      s1_b <= '0;
    end else if (in_xfer) begin
      s1_a <= in_a;
      s1_b <= in_b;
    end
  end

  assign sum_w = {1'b0, s1_a} + {1'b0, s1_b};

`ifdef ADD_PIPE2_SAT_EN
  assign sum_d = sum_w[DW] ? {DW{1'b1}} : sum_w[DW-1:0];
`else
  assign sum_d = sum_w[DW-1:0];
`endif

  // Stage 2 result register; holds during a stall
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_sum   <= '0;
      out_carry <= 1'b0;
    end else if (s2_adv && s1_v) begin
      out_sum   <= sum_d;
      out_carry <= sum_w[DW];
    end
  end

  // Completed output transfers, wrapping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         out_cnt <= '0;
    else if (out_xfer) out_cnt <= out_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_add_pipe2.sv
// Directed self-checking bench for add_pipe2 (DW=4, CNT_W=8).
module tb_add_pipe2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic       out_carry;
  logic [7:0] out_cnt;

  int total = 0;
  int bad   = 0;

  add_pipe2 #(.DW(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic rdy);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = rdy;
    #1;
  endtask

  logic [3:0] third_sum;

  initial begin
`ifdef ADD_PIPE2_SAT_EN
    third_sum = 4'd15;
`else
    third_sum = 4'd1;
`endif
    rstn = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",   32'(out_sum),   32'd0);
    chk("rst_carry", 32'(out_carry), 32'd0);
    chk("rst_cnt",   32'(out_cnt),   32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);
    rstn = 1'b1;

    // Single pair, two-cycle latency
    @(negedge clk); drive(1'b1, 4'd1, 4'd2, 1'b1);
    @(negedge clk); drive(1'b0, 4'd0, 4'd0, 1'b1);
    chk("lat_v1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_v2",  32'(out_valid), 32'd1);
    chk("lat_sum", 32'(out_sum),   32'd3);
    chk("lat_c",   32'(out_carry), 32'd0);
    @(negedge clk);
    chk("lat_done", 32'(out_valid), 32'd0);
    chk("lat_cnt",  32'(out_cnt),   32'd1);

    // Back-to-back pairs
    drive(1'b1, 4'd3, 4'd4, 1'b1);
    @(negedge clk); drive(1'b1, 4'd7, 4'd8, 1'b1);
    @(negedge clk); drive(1'b1, 4'd9, 4'd8, 1'b1);
    chk("b2b_s0", 32'(out_sum),   32'd7);
    chk("b2b_c0", 32'(out_carry), 32'd0);
    chk("b2b_v0", 32'(out_valid), 32'd1);
    @(negedge clk); drive(1'b0, 4'd0, 4'd0, 1'b1);
    chk("b2b_s1", 32'(out_sum),   32'd15);
    chk("b2b_c1", 32'(out_carry), 32'd0);
    chk("b2b_v1", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("b2b_s2", 32'(out_sum),   32'(third_sum));
    chk("b2b_c2", 32'(out_carry), 32'd1);
    chk("b2b_v2", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("b2b_end", 32'(out_valid), 32'd0);
    chk("b2b_cnt", 32'(out_cnt),   32'd4);

    // Stall with three pairs offered
    drive(1'b1, 4'd1, 4'd1, 1'b0);
    @(negedge clk); drive(1'b1, 4'd2, 4'd2, 1'b0);
    @(negedge clk); drive(1'b1, 4'd3, 4'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rdy", 32'(in_ready),  32'd0);
      chk("stall_v",   32'(out_valid), 32'd1);
      chk("stall_sum", 32'(out_sum),   32'd2);
      chk("stall_cnt", 32'(out_cnt),   32'd4);
      @(negedge clk);
    end
    drive(1'b1, 4'd3, 4'd3, 1'b1);
    chk("unstall_rdy", 32'(in_ready), 32'd1);
    @(negedge clk); drive(1'b0, 4'd0, 4'd0, 1'b1);
    chk("drain_s1", 32'(out_sum),   32'd4);
    chk("drain_v1", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("drain_s2", 32'(out_sum),   32'd6);
    chk("drain_v2", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("drain_end", 32'(out_valid), 32'd0);
    chk("drain_cnt", 32'(out_cnt),   32'd7);

    // FULL with simultaneous output and input transfer
    drive(1'b1, 4'd4, 4'd4, 1'b0);
    @(negedge clk); drive(1'b1, 4'd1, 4'd1, 1'b0);
    @(negedge clk); drive(1'b0, 4'd0, 4'd0, 1'b0);
    chk("full_rdy0", 32'(in_ready), 32'd0);
    drive(1'b1, 4'd5, 4'd6, 1'b1);
    chk("full_rdy1", 32'(in_ready), 32'd1);
    chk("full_s0",   32'(out_sum),  32'd8);
    @(negedge clk); drive(1'b0, 4'd0, 4'd0, 1'b1);
    chk("full_s1", 32'(out_sum),   32'd2);
    chk("full_v1", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("full_s2", 32'(out_sum),   32'd11);
    chk("full_v2", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("full_end", 32'(out_valid), 32'd0);
    chk("full_cnt", 32'(out_cnt),   32'd10);

    // Asynchronous reset while FULL
    drive(1'b1, 4'd1, 4'd1, 1'b0);
    @(negedge clk); drive(1'b1, 4'd2, 4'd2, 1'b0);
    @(negedge clk); drive(1'b0, 4'd0, 4'd0, 1'b0);
    chk("pre_arst_v", 32'(out_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_v",   32'(out_valid), 32'd0);
    chk("arst_cnt", 32'(out_cnt),   32'd0);
    chk("arst_rdy", 32'(in_ready),  32'd1);
    @(negedge clk); rstn = 1'b1;
    drive(1'b0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_arst_v",   32'(out_valid), 32'd0);
      chk("post_arst_cnt", 32'(out_cnt),   32'd0);
    end

    // Counter wrap: continuous stream, transfers start on the third edge
    drive(1'b1, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 257; i++) begin
      @(negedge clk);
      in_a = 4'(i);
      in_b = 4'(i + 1);
    end
    drive(1'b1, in_a, in_b, 1'b0);
    chk("cnt_255", 32'(out_cnt), 32'd255);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cnt_stall", 32'(out_cnt),  32'd255);
      chk("cnt_rdy",   32'(in_ready), 32'd0);
    end
    drive(1'b0, 4'd0, 4'd0, 1'b1);
    @(negedge clk);
    chk("cnt_wrap", 32'(out_cnt), 32'd0);
    @(negedge clk);
    chk("cnt_after", 32'(out_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
